// File: rtl/forno_pkg.sv
// forno_pkg: shared state encoding and synchroniser depth for the oven controller
package forno_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, COOK = 2'd1, PAUSE = 2'd2, DONE = 2'd3} estado_t;
    localparam int SYNC_DEPTH = 2;
endpackage

// File: rtl/sincroniza_botao.sv
// sincroniza_botao: multi-FF synchroniser with falling-edge press detector
module sincroniza_botao
    import forno_pkg::*;
#(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic sync,
    output logic fall
);
    logic [SYNC_DEPTH-1:0] ff;
    logic prev;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            ff   <= {SYNC_DEPTH{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            ff   <= {ff[SYNC_DEPTH-2:0], din};
            prev <= ff[SYNC_DEPTH-1];
        end
    assign sync = ff[SYNC_DEPTH-1];
    assign fall = prev & ~sync;
endmodule

// File: rtl/controle_forno_param.sv
// controle_forno_param: microwave cook-cycle controller with countdown, power duty
// cycling and one-cycle S/R pulses for the magnetron latch
module controle_forno_param
    import forno_pkg::*;
#(
    parameter int TIME_W     = 8,
    parameter int TICK_DIV   = 1000,
    parameter int PWR_LEVELS = 4,
    localparam int PWR_W     = $clog2(PWR_LEVELS),
    localparam int TICK_W    = $clog2(TICK_DIV)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              startn,
    input  logic              stopn,
    input  logic              clearn,
    input  logic              door_closed,
    input  logic [TIME_W-1:0] time_load,
    input  logic [PWR_W-1:0]  power_sel,
    output logic              mag_on,
    output logic              S,
    output logic              R,
    output logic              done,
    output logic [1:0]        state,
    output logic [TIME_W-1:0] time_left
);
    estado_t st, st_n;
    logic [TICK_W-1:0] tick, tick_n;
    logic [PWR_W-1:0] slot, slot_n, pwr_lat, pwr_n;
    logic [TIME_W-1:0] time_n;
    logic start_ev, stop_ev, clr_ev, door_sync, door_fall;
    logic unused_s, unused_t, unused_c;
    logic s_n, r_n, mag_n, done_n, wrap;

    sincroniza_botao #(.RST_VAL(1'b1)) u_start (.clk, .resetn, .din(startn), .sync(unused_s), .fall(start_ev));
    sincroniza_botao #(.RST_VAL(1'b1)) u_stop  (.clk, .resetn, .din(stopn),  .sync(unused_t), .fall(stop_ev));
    sincroniza_botao #(.RST_VAL(1'b1)) u_clear (.clk, .resetn, .din(clearn), .sync(unused_c), .fall(clr_ev));
    // door falling edge is the "door opened" event that releases DONE
    sincroniza_botao #(.RST_VAL(1'b0)) u_door  (.clk, .resetn, .din(door_closed), .sync(door_sync), .fall(door_fall));

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            st        <= IDLE;
            tick      <= '0;
            slot      <= '0;
            pwr_lat   <= '0;
            time_left <= '0;
            S         <= 1'b0;
            R         <= 1'b0;
            mag_on    <= 1'b0;
            done      <= 1'b0;
        end else begin
            st        <= st_n;
            tick      <= tick_n;
            slot      <= slot_n;
            pwr_lat   <= pwr_n;
            time_left <= time_n;
            S         <= s_n;
            R         <= r_n;
            mag_on    <= mag_n;
            done      <= done_n;
        end

    always_comb begin
        st_n   = st;
        tick_n = tick;
        slot_n = slot;
        pwr_n  = pwr_lat;
        time_n = time_left;
        wrap   = tick == TICK_W'(TICK_DIV - 1);
        if (clr_ev) begin
            st_n   = IDLE;
            time_n = '0;
            tick_n = '0;
            slot_n = '0;
        end else
            case (st)
                IDLE:
                    if (start_ev && !stop_ev && door_sync && time_load != '0) begin
                        st_n   = COOK;
                        time_n = time_load;
                        pwr_n  = power_sel;
                        tick_n = '0;
                        slot_n = '0;
                    end
                COOK:
                    if (!door_sync || stop_ev)
                        st_n = PAUSE;
                    else if (wrap) begin
                        tick_n = '0;
                        slot_n = slot == PWR_W'(PWR_LEVELS - 1) ? '0 : slot + 1'b1;
                        time_n = time_left == '0 ? '0 : time_left - 1'b1;
                        st_n   = time_left <= TIME_W'(1) ? DONE : COOK;
                    end else
                        tick_n = tick + 1'b1;
                PAUSE:
                    if (stop_ev) begin
                        st_n   = IDLE;
                        time_n = '0;
                        tick_n = '0;
                        slot_n = '0;
                    end else if (start_ev && door_sync)
                        st_n = COOK;
                DONE:
                    if (start_ev || stop_ev || door_fall) begin
                        st_n   = IDLE;
                        tick_n = '0;
                        slot_n = '0;
                    end
            endcase
    end

    always_comb begin
        s_n    = st_n == COOK && st != COOK;
        r_n    = st == COOK && st_n != COOK;
        mag_n  = st_n == COOK && slot_n <= pwr_n;
        done_n = st_n == DONE;
    end

    assign state = st;
endmodule

// File: tb/tb_controle_forno_param.sv
// tb_controle_forno_param: directed scoreboard bench for the oven controller
module tb_controle_forno_param;
    logic clk = 1'b0, resetn, startn, stopn, clearn, door_closed;
    logic [7:0] time_load;
    logic [1:0] power_sel;
    logic mag_on, S, R, done;
    logic [1:0] state;
    logic [7:0] time_left;

    typedef struct {string tag; logic [15:0] exp;} item_t;
    item_t q[$];
    int vecs = 0, errs = 0;
    int s_cnt = 0, r_cnt = 0, s_long = 0, both = 0;
    logic s_prev = 1'b0;
    int s_save, r_save;

    localparam logic [1:0] ID = 2'd0, CK = 2'd1, PA = 2'd2, DN = 2'd3;

    controle_forno_param #(.TIME_W(8), .TICK_DIV(4), .PWR_LEVELS(4)) dut (
        .clk(clk), .resetn(resetn), .startn(startn), .stopn(stopn), .clearn(clearn),
        .door_closed(door_closed), .time_load(time_load), .power_sel(power_sel),
        .mag_on(mag_on), .S(S), .R(R), .done(done), .state(state), .time_left(time_left)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (S && s_prev) s_long++;
        if (S && R) both++;
        s_cnt += int'(S);
        r_cnt += int'(R);
        s_prev = S;
    end

    function automatic logic [15:0] pk(logic [1:0] st, logic m, logic s, logic r, logic d, logic [7:0] t);
        return {2'b00, st, m, s, r, d, t};
    endfunction

    function automatic logic [15:0] obs();
        return pk(state, mag_on, S, R, done, time_left);
    endfunction

    task automatic push(input string tag, input logic [15:0] e);
        item_t it;
        it.tag = tag;
        it.exp = e;
        q.push_back(it);
    endtask

    task automatic chk(input logic [15:0] o);
        item_t it;
        if (q.size() == 0) begin
            errs++;
            $error("FAIL scoreboard_empty observed=%h", o);
        end else begin
            it = q.pop_front();
            vecs++;
            assert (o === it.exp) else begin
                errs++;
                $error("FAIL %s observed=%h expected=%h", it.tag, o, it.exp);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int b);
        if (b == 0) startn = 1'b0; else if (b == 1) stopn = 1'b0; else clearn = 1'b0;
        cyc(2);
        startn = 1'b1;
        stopn  = 1'b1;
        clearn = 1'b1;
        cyc(1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
        door_closed = 1'b0; time_load = '0; power_sel = '0;
        cyc(2);
        push("reset", pk(ID, 0, 0, 0, 0, 0)); chk(obs());
        resetn = 1'b1;
        door_closed = 1'b1;
        cyc(3);
        // basic cook at full power
        time_load = 8'd3; power_sel = 2'd3;
        press(0);
        push("basic_entry", pk(CK, 1, 1, 0, 0, 3)); chk(obs());
        cyc(4); push("basic_t2", pk(CK, 1, 0, 0, 0, 2)); chk(obs());
        cyc(4); push("basic_t1", pk(CK, 1, 0, 0, 0, 1)); chk(obs());
        cyc(4); push("basic_done", pk(DN, 0, 0, 1, 1, 0)); chk(obs());
        cyc(1); push("basic_done_hold", pk(DN, 0, 0, 0, 1, 0)); chk(obs());
        press(2); push("done_clear", pk(ID, 0, 0, 0, 0, 0)); chk(obs());
        // door interlock
        press(0);
        push("door_entry", pk(CK, 1, 1, 0, 0, 3)); chk(obs());
        cyc(4); push("door_t2", pk(CK, 1, 0, 0, 0, 2)); chk(obs());
        door_closed = 1'b0;
        cyc(3); push("door_pause", pk(PA, 0, 0, 1, 0, 2)); chk(obs());
        door_closed = 1'b1;
        cyc(3); push("door_frozen", pk(PA, 0, 0, 0, 0, 2)); chk(obs());
        press(0); push("door_resume", pk(CK, 1, 1, 0, 0, 2)); chk(obs());
        cyc(2); push("door_t1", pk(CK, 1, 0, 0, 0, 1)); chk(obs());
        cyc(4); push("door_done", pk(DN, 0, 0, 1, 1, 0)); chk(obs());
        press(2);
        // stop then cancel
        time_load = 8'd5;
        press(0); push("stop_entry", pk(CK, 1, 1, 0, 0, 5)); chk(obs());
        s_save = s_cnt;
        press(1); push("stop_pause", pk(PA, 0, 0, 1, 0, 5)); chk(obs());
        press(1); push("stop_cancel", pk(ID, 0, 0, 0, 0, 0)); chk(obs());
        push("stop_no_s", 16'(s_save)); chk(16'(s_cnt));
        // power duty cycle at level 1: two seconds on, two off
        time_load = 8'd8; power_sel = 2'd1;
        press(0);
        for (int k = 0; k < 32; k++)
            push($sformatf("duty_k%0d", k), pk(CK, ((k / 4) % 4) <= 1, k == 0, 0, 0, 8'(8 - k / 4)));
        for (int k = 0; k < 32; k++) begin
            chk(obs());
            cyc(1);
        end
        push("duty_done", pk(DN, 0, 0, 1, 1, 0)); chk(obs());
        press(2);
        // rejected starts
        s_save = s_cnt;
        door_closed = 1'b0; time_load = 8'd5;
        cyc(3);
        press(0); push("rej_door", pk(ID, 0, 0, 0, 0, 0)); chk(obs());
        door_closed = 1'b1; time_load = 8'd0;
        cyc(3);
        press(0); push("rej_zero", pk(ID, 0, 0, 0, 0, 0)); chk(obs());
        push("rej_no_s", 16'(s_save)); chk(16'(s_cnt));
        // clear beats start in PAUSE
        time_load = 8'd4; power_sel = 2'd3;
        press(0);
        press(1); push("prio_pause", pk(PA, 0, 0, 1, 0, 4)); chk(obs());
        s_save = s_cnt;
        clearn = 1'b0; startn = 1'b0;
        cyc(2);
        clearn = 1'b1; startn = 1'b1;
        cyc(1);
        push("prio_clear", pk(ID, 0, 0, 0, 0, 0)); chk(obs());
        push("prio_no_s", 16'(s_save)); chk(16'(s_cnt));
        // asynchronous reset mid-cook
        press(0);
        cyc(2);
        push("pre_reset", pk(CK, 1, 0, 0, 0, 4)); chk(obs());
        r_save = r_cnt;
        #2 resetn = 1'b0;
        #1 push("async_reset", pk(ID, 0, 0, 0, 0, 0)); chk(obs());
        cyc(1);
        resetn = 1'b1;
        cyc(2);
        push("reset_no_r", 16'(r_save)); chk(16'(r_cnt));
        push("s_one_cycle", 16'(0)); chk(16'(s_long));
        push("s_r_exclusive", 16'(0)); chk(16'(both));
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
